// File: rtl/proc_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package proc_pkg;

    localparam int unsigned DATA_W = 18;
    localparam int unsigned ADDR_W = 18;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CPU_RET = 1'b1
    } arb_state_e;

    // Owner of the read data arriving from the RAM this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_RD   = 2'd2
    } owner_e;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter; sat flags that the reader has been denied MAX_WAIT cycles.
module starve_counter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; hold at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sat   <= (CNT_MAX == '0);
        end else begin
            cnt_q <= cnt_d;
            sat   <= (cnt_d == CNT_MAX);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data-memory arbiter between the CPU M stage and the pixel reader,
// with starvation protection for the reader.
module data_mem_arbiter
    import proc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       cpu_gnt;
    logic       wait_sat;
    logic       cnt_inc;
    logic       cnt_clr;
    mem_req_t   mem_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Arbitration and next state; everything stays quiet while reset is held
    always_comb begin
        state_d   = state_q;
        owner_d   = OWN_NONE;
        cpu_gnt   = 1'b0;
        rd_gnt    = 1'b0;
        cpu_stall = 1'b0;
        if (rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rd_req && (!cpu_req || wait_sat)) begin
                        rd_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                    // A granted read still stalls: its data lands next cycle
                    cpu_stall = (cpu_req && !cpu_gnt) || (cpu_gnt && !cpu_we);
                    if (cpu_gnt && !cpu_we) begin
                        state_d = ST_CPU_RET;
                    end
                end
                ST_CPU_RET: begin
                    rd_gnt  = rd_req;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (rd_gnt) begin
                owner_d = OWN_RD;
            end else if (cpu_gnt && !cpu_we) begin
                owner_d = OWN_CPU;
            end
        end
    end

    assign cnt_inc = rd_req && !rd_gnt;
    assign cnt_clr = rd_gnt || !rd_req;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (wait_sat)
    );

    // RAM port follows whichever requester holds the grant
    always_comb begin
        mem_req = '0;
        if (rd_gnt) begin
            mem_req.en   = 1'b1;
            mem_req.addr = rd_addr;
        end else if (cpu_gnt) begin
            mem_req.en    = 1'b1;
            mem_req.we    = cpu_we;
            mem_req.addr  = cpu_addr;
            mem_req.wdata = cpu_wdata;
        end
    end

    assign mem_en    = mem_req.en;
    assign mem_we    = mem_req.we;
    assign mem_addr  = mem_req.addr;
    assign mem_wdata = mem_req.wdata;

    // Steer the RAM read data to the owner recorded at grant time
    always_comb begin
        cpu_rdata = '0;
        rd_rdata  = '0;
        rd_valid  = 1'b0;
        if (rst) begin
            unique case (owner_q)
                OWN_CPU: begin
                    cpu_rdata = mem_rdata;
                end
                OWN_RD: begin
                    rd_valid = 1'b1;
                    rd_rdata = mem_rdata;
                end
                default: begin
                    rd_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus randomized checking of data_mem_arbiter against a cycle-level reference model.
module tb_data_mem_arbiter;

    localparam int unsigned MW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [17:0] cpu_addr;
    logic [17:0] cpu_wdata;
    logic [17:0] cpu_rdata;
    logic        cpu_stall;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_gnt;
    logic [17:0] rd_rdata;
    logic        rd_valid;
    logic        mem_en;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_rdata  (rd_rdata),
        .rd_valid  (rd_valid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port RAM, one-cycle read latency
    logic [17:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    // Reference model state
    int          total = 0;
    int          bad = 0;
    int          m_wait = 0;
    bit          m_cpu_ret = 1'b0;
    bit          m_rd_ret = 1'b0;
    logic [17:0] m_cpu_data = '0;
    logic [17:0] m_rd_data = '0;
    logic [17:0] ref_mem [int];
    bit          obs_rd_gnt;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 18'h0;
    endfunction

    // One clock cycle: drive at negedge, check after settling, advance model at posedge
    task automatic step(input bit r, input bit cr, input bit cw, input int ca,
                        input logic [17:0] cd, input bit rr, input int ra);
        bit e_rg, e_cg, e_st;
        @(negedge clk);
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = 18'(ca);
        cpu_wdata = cd; rd_req = rr; rd_addr = 18'(ra);
        #1;
        e_rg = 1'b0; e_cg = 1'b0; e_st = 1'b0;
        if (r) begin
            e_rg = rr && (m_cpu_ret || !cr || m_wait == int'(MW));
            e_cg = cr && !m_cpu_ret && !e_rg;
            e_st = cr && !m_cpu_ret && (!e_cg || !cw);
        end
        chk("rd_gnt", 18'(rd_gnt), 18'(e_rg));
        chk("cpu_stall", 18'(cpu_stall), 18'(e_st));
        chk("mem_en", 18'(mem_en), 18'(e_rg || e_cg));
        chk("mem_we", 18'(mem_we), 18'(e_cg && cw));
        if (e_rg)           chk("mem_addr_rd", mem_addr, 18'(ra));
        else if (e_cg)      chk("mem_addr_cpu", mem_addr, 18'(ca));
        if (e_cg && cw)     chk("mem_wdata", mem_wdata, cd);
        if (!r) begin
            chk("mem_addr_rst", mem_addr, 18'h0);
            chk("mem_wdata_rst", mem_wdata, 18'h0);
        end
        chk("rd_valid", 18'(rd_valid), 18'(r && m_rd_ret));
        chk("rd_rdata", rd_rdata, (r && m_rd_ret) ? m_rd_data : 18'h0);
        chk("cpu_rdata", cpu_rdata, (r && m_cpu_ret) ? m_cpu_data : 18'h0);
        obs_rd_gnt = rd_gnt;
        @(posedge clk);
        if (!r) begin
            m_wait = 0; m_cpu_ret = 1'b0; m_rd_ret = 1'b0;
        end else begin
            m_wait    = (rr && !e_rg) ? ((m_wait < int'(MW)) ? m_wait + 1 : int'(MW)) : 0;
            m_rd_ret  = e_rg;
            if (e_rg) m_rd_data = ref_rd(ra);
            m_cpu_ret = e_cg && !cw;
            if (m_cpu_ret) m_cpu_data = ref_rd(ca);
            if (e_cg && cw) ref_mem[ca] = cd;
        end
    endtask

    initial begin
        int n;
        bit rp;
        int ra;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; rd_req = 1'b0; rd_addr = '0;

        // Reset with requesters active: everything silent
        step(0, 1, 1, 'h10, 18'h1234, 1, 'h100);
        step(0, 1, 0, 'h10, 18'h0, 0, 0);
        step(1, 0, 0, 0, 18'h0, 0, 0);

        // CPU write then read back with one-cycle return
        step(1, 1, 1, 'h10, 18'h2ABCD, 0, 0);
        step(1, 1, 0, 'h10, 18'h0, 0, 0);
        step(1, 1, 0, 'h10, 18'h0, 0, 0);
        step(1, 0, 0, 0, 18'h0, 0, 0);

        // Preload reader addresses
        for (int i = 0; i < 4; i++) step(1, 1, 1, 'h100 + i, 18'(32'h15000 + i * 7), 0, 0);

        // Starvation: reader wins on the ninth cycle of a continuous request
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, 'h20, 18'(i), 1, 'h102);
            n++;
            if (obs_rd_gnt) break;
        end
        chk("starve_grant_cycle", 18'(n), 18'(9));
        step(1, 1, 1, 'h21, 18'h3, 1, 'h103);
        step(1, 0, 0, 0, 18'h0, 0, 0);
        step(1, 0, 0, 0, 18'h0, 0, 0);

        // Reader back-to-back with CPU idle
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 18'h0, 1, 'h100 + i);
        step(1, 0, 0, 0, 18'h0, 0, 0);

        // Reader granted during the CPU return cycle
        step(1, 1, 0, 'h10, 18'h0, 0, 0);
        step(1, 1, 0, 'h10, 18'h0, 1, 'h101);
        step(1, 0, 0, 0, 18'h0, 0, 0);

        // Reset right after a reader grant discards the return
        step(1, 0, 0, 0, 18'h0, 1, 'h100);
        step(0, 1, 1, 'h5, 18'h777, 1, 'h101);
        step(0, 0, 0, 0, 18'h0, 0, 0);
        step(1, 0, 0, 0, 18'h0, 0, 0);
        step(1, 0, 0, 0, 18'h0, 0, 0);

        // Randomized traffic over a preloaded window
        for (int i = 0; i < 16; i++) step(1, 1, 1, i, 18'($urandom), 0, 0);
        rp = 1'b0; ra = 0;
        for (int i = 0; i < 400; i++) begin
            bit r, cr, cw;
            if (!rp && $urandom_range(0, 2) != 0) begin
                rp = 1'b1;
                ra = int'($urandom_range(0, 15));
            end
            r  = ($urandom_range(0, 99) != 0);
            cr = ($urandom_range(0, 2) != 0);
            cw = $urandom_range(0, 1) == 1;
            step(r, cr, cw, int'($urandom_range(0, 15)), 18'($urandom), rp, ra);
            if (obs_rd_gnt) rp = 1'b0;
        end
        step(1, 0, 0, 0, 18'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
